// File: rtl/pb_pkg.sv
// Shared definitions for the protobuf varint field scheduler.
// Holds the field/key/value widths, the varint wire type and the
// scheduler state encoding used by pb_field_sched.
package pb_pkg;

  localparam int FIELD_ID_W       = 29;
  localparam int KEY_W            = 32;
  localparam int VALUE_W          = 64;
  localparam int VARINT_MAX_BYTES = 10;

  localparam logic [2:0] WT_VARINT = 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    VAL  = 2'd2
  } pb_sched_state_t;

  // sint64 mapping: small magnitudes of either sign become small unsigned values.
  function automatic logic [VALUE_W-1:0] zigzag64(input logic [VALUE_W-1:0] v);
    return (v << 1) ^ {VALUE_W{v[VALUE_W-1]}};
  endfunction

endpackage

// File: rtl/pb_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req from index ptr upward with wrap and returns the first set bit.
// Ports:
//   req       in  N   request vector
//   ptr       in  PW  search start index (0..N-1)
//   grant     out N   one-hot grant (all zero when no request)
//   grant_idx out PW  encoded index of the granted bit (0 when no request)
//   any       out 1   at least one request present
module pb_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int j;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/pb_field_sched.sv
// Protobuf varint field scheduler.
// Round-robin picks one of NUM_REQ requesters, captures its field id and
// value, then streams the key varint ({field_id, wire type 0}) followed by
// the value varint, one byte per accepted cycle.
// Build option: define PB_ZIGZAG_EN to zigzag-encode values from requesters
// that flag req_signed; without it req_signed has no effect.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_valid     per-requester request, held until req_ready
//   req_ready     one-hot capture pulse (combinational, IDLE only)
//   req_field_id  packed field ids, slice i = [29*i +: 29]
//   req_value     packed values,    slice i = [64*i +: 64]
//   req_signed    per-requester sint64 flag
//   out_valid/out_ready/out_byte  byte stream handshake
//   out_sop       first key byte of a field
//   out_last      final value byte of a field
//   busy          scheduler not idle
module pb_field_sched
  import pb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*FIELD_ID_W-1:0] req_field_id,
  input  logic [NUM_REQ*VALUE_W-1:0]    req_value,
  input  logic [NUM_REQ-1:0]            req_signed,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_byte,
  output logic                          out_sop,
  output logic                          out_last,
  output logic                          busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  pb_sched_state_t      state_q, state_d;
  logic [PW-1:0]        rr_ptr_q;
  logic [VALUE_W-1:0]   sr_q;
  logic [VALUE_W-1:0]   val_q;
  logic                 first_q;   // next HDR byte is the first of the field

  logic [NUM_REQ-1:0]   gnt;
  logic [PW-1:0]        gnt_idx;
  logic                 gnt_any;
  logic                 more;
  logic                 accept;
  logic                 take;

  logic [FIELD_ID_W-1:0] gnt_fid;
  logic [VALUE_W-1:0]    gnt_raw;
  logic                  gnt_sgn;
  logic [VALUE_W-1:0]    gnt_val;

  pb_rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .any       (gnt_any)
  );

  assign more    = |sr_q[VALUE_W-1:7];
  assign accept  = out_valid && out_ready;
  assign take    = (state_q == IDLE) && gnt_any;

  assign gnt_fid = req_field_id[FIELD_ID_W*gnt_idx +: FIELD_ID_W];
  assign gnt_raw = req_value[VALUE_W*gnt_idx +: VALUE_W];

`ifdef PB_ZIGZAG_EN
  assign gnt_sgn = req_signed[gnt_idx];
`else
  // Signed flag is accepted on the port but never alters the value here.
  assign gnt_sgn = 1'b0 && req_signed[gnt_idx];
`endif

  assign gnt_val = gnt_sgn ? zigzag64(gnt_raw) : gnt_raw;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_any) state_d = HDR;
      HDR:     if (accept && !more) state_d = VAL;
      VAL:     if (accept && !more) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; the byte is a pure function of held state, so a stall
  // keeps byte/sop/last stable without extra registers.
  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    out_sop   = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: req_ready = gnt;
      HDR: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_byte  = {more, sr_q[6:0]};
        out_sop   = first_q;
      end
      VAL: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_byte  = {more, sr_q[6:0]};
        out_last  = !more;
      end
      default: ;
    endcase
  end

  // Datapath: capture on grant, shift 7 bits per accepted byte, swap in the
  // value once the key is exhausted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      sr_q     <= '0;
      val_q    <= '0;
      first_q  <= 1'b0;
    end else if (take) begin
      val_q    <= gnt_val;
      sr_q     <= {{(VALUE_W-KEY_W){1'b0}}, gnt_fid, WT_VARINT};
      rr_ptr_q <= (gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      first_q  <= 1'b1;
    end else if (accept) begin
      first_q <= 1'b0;
      if (more)                 sr_q <= sr_q >> 7;
      else if (state_q == HDR)  sr_q <= val_q;
      else                      sr_q <= '0;
    end
  end

endmodule

// File: tb/tb_pb_field_sched.sv
// Scoreboard bench for pb_field_sched: stimulus pushes expected bytes and
// grant indices into queues, a negedge monitor pops and compares.
module tb_pb_field_sched;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*29-1:0] req_field_id = '0;
  logic [N*64-1:0] req_value = '0;
  logic [N-1:0]    req_signed = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [7:0]      out_byte;
  logic            out_sop;
  logic            out_last;
  logic            busy;

  always #5 clk = ~clk;

  pb_field_sched #(.NUM_REQ(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_field_id (req_field_id),
    .req_value    (req_value),
    .req_signed   (req_signed),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_byte     (out_byte),
    .out_sop      (out_sop),
    .out_last     (out_last),
    .busy         (busy)
  );

  typedef struct packed {
    logic [7:0] b;
    logic       sop;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;
  int   gnt_cnt = 0;
  int   rdy0_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, req, $time);
    end
  endtask

  task automatic expb(input logic [7:0] b, input bit sop, input bit last);
    exp_t e;
    e.b = b; e.sop = sop; e.last = last;
    exp_q.push_back(e);
  endtask

  // Monitor / scoreboard
  initial begin
    bit         hold_v = 1'b0;
    logic [10:0] held = '0;
    bit         prev_last = 1'b0;
    exp_t       e;
    int         g;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (busy) busy_cnt++;
        if (|req_ready) begin
          gnt_cnt++;
          if (req_ready[0]) rdy0_cnt++;
          if (gnt_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_grant: got %b expected none", req_ready);
          end else begin
            g = gnt_q.pop_front();
            chk("grant", 64'(req_ready), 64'(1) << g);
          end
        end
        if (hold_v) chk("stall_hold", 64'({out_valid, out_sop, out_last, out_byte}), 64'(held));
        hold_v = out_valid && !out_ready;
        held   = {out_valid, out_sop, out_last, out_byte};
        if (prev_last) chk("idle_bubble", 64'(busy), 64'(0));
        prev_last = out_valid && out_ready && out_last;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_byte: got %h expected none", out_byte);
          end else begin
            e = exp_q.pop_front();
            chk("byte", 64'({out_sop, out_last, out_byte}), 64'({e.sop, e.last, e.b}));
          end
        end
      end
    end
  end

  task automatic issue(input int i, input logic [28:0] id, input logic [63:0] v, input bit s);
    bit got = 1'b0;
    req_field_id[29*i +: 29] = id;
    req_value[64*i +: 64]    = v;
    req_signed[i]            = s;
    req_valid[i]             = 1'b1;
    gnt_q.push_back(i);
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL grant_timeout: requester %0d never granted", i);
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d bytes outstanding busy=%0b", exp_q.size(), busy);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    bit got;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_sop",   64'(out_sop),   64'(0));
    chk("rst_out_last",  64'(out_last),  64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_out_byte",  64'(out_byte),  64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // field 1, value 150 from requester 0
    busy_cnt = 0; rdy0_cnt = 0;
    expb(8'h08, 1, 0); expb(8'h96, 0, 0); expb(8'h01, 0, 1);
    issue(0, 29'd1, 64'd150, 1'b0);
    drain();
    chk("t1_busy_cycles", 64'(busy_cnt), 64'(3));
    chk("t1_ready_pulses", 64'(rdy0_cnt), 64'(1));

    // field 150, value 0 from requester 2
    expb(8'hB0, 1, 0); expb(8'h09, 0, 0); expb(8'h00, 0, 1);
    issue(2, 29'd150, 64'd0, 1'b0);
    drain();

    // maximum key and value lengths from requester 3 (pointer wraps to 0)
    expb(8'hF8, 1, 0); expb(8'hFF, 0, 0); expb(8'hFF, 0, 0); expb(8'hFF, 0, 0); expb(8'h0F, 0, 0);
    for (int k = 0; k < 9; k++) expb(8'hFF, 0, 0);
    expb(8'h01, 0, 1);
    issue(3, 29'h1FFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    drain();

    // all requesters valid: order 0,1,2,3,0
    for (int i = 0; i < N; i++) begin
      req_field_id[29*i +: 29] = 29'(i + 1);
      req_value[64*i +: 64]    = 64'(i + 1);
      req_signed[i]            = 1'b0;
    end
    gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(2); gnt_q.push_back(3); gnt_q.push_back(0);
    expb(8'h08, 1, 0); expb(8'h01, 0, 1);
    expb(8'h10, 1, 0); expb(8'h02, 0, 1);
    expb(8'h18, 1, 0); expb(8'h03, 0, 1);
    expb(8'h20, 1, 0); expb(8'h04, 0, 1);
    expb(8'h08, 1, 0); expb(8'h01, 0, 1);
    base = gnt_cnt;
    req_valid = '1;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (gnt_cnt >= base + 5) got = 1'b1;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL rr_timeout: got %0d grants expected 5", gnt_cnt - base);
    end
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // stall pattern 1010 during field 1 / 150
    expb(8'h08, 1, 0); expb(8'h96, 0, 0); expb(8'h01, 0, 1);
    fork
      issue(0, 29'd1, 64'd150, 1'b0);
      begin
        for (int c = 0; c < 16; c++) begin
          @(posedge clk); #1;
          out_ready = (c % 2 == 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // signed value handling
`ifdef PB_ZIGZAG_EN
    expb(8'h08, 1, 0); expb(8'h01, 0, 1);
    issue(1, 29'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    drain();
    expb(8'h08, 1, 0); expb(8'h03, 0, 1);
    issue(1, 29'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    drain();
`else
    expb(8'h08, 1, 0);
    for (int k = 0; k < 9; k++) expb(8'hFF, 0, 0);
    expb(8'h01, 0, 1);
    issue(1, 29'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    drain();
`endif

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    chk("grants_consumed",  64'(gnt_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
